// File: rtl/sd_sector_sequencer.sv
// sd_sector_sequencer: turns ZPU register strobes into one-hot sd_rd/sd_wr
// sector requests towards the HPS, owns the ZPU side of the 512-byte sector
// buffer and latches image mount events into firmware-visible status.
module sd_sector_sequencer #(
   parameter int          NSLOT   = 3,
   parameter logic [23:0] TIMEOUT = 24'd8000000,
   parameter int          ABITS   = 9
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [31:0]      zpu_out2,
   input  logic [31:0]      zpu_out3,
   input  logic             zpu_io_wr,
   input  logic             zpu_data_wr,
   input  logic             zpu_data_rd,
   output logic [7:0]       zpu_in2,
   output logic [31:0]      zpu_in3,
   output logic             zpu_err,
   output logic [ABITS-1:0] buf_addr,
   output logic             buf_wr,
   input  logic [7:0]       buf_q,
   output logic [31:0]      sd_lba,
   output logic [NSLOT-1:0] sd_rd,
   output logic [NSLOT-1:0] sd_wr,
   input  logic             sd_ack,
   input  logic [NSLOT-1:0] img_mounted,
   input  logic             img_readonly,
   input  logic [31:0]      img_size,
   input  logic [7:0]       ioctl_index,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

   state_t state, state_nxt;

   logic       lba_sel, block_rd, block_wr;
   logic [2:0] drv_num;
   logic [1:0] slot;

   assign lba_sel  = zpu_out2[0];
   assign block_rd = zpu_out2[1];
   assign block_wr = zpu_out2[2];
   assign drv_num  = zpu_out2[5:3];
   // drv_num bit 1 does not take part in slot selection
   assign slot     = {drv_num[2], drv_num[0]};

   logic unused_bits;
   assign unused_bits = ^{zpu_out2[31:6], ioctl_index[5:0], drv_num[1]};

   // strobe history for edge detection
   logic data_wr_p1, data_wr_p2, data_wr_p3;
   logic data_rd_p1, block_rd_p1, block_wr_p1, ack_p1, mnt_p1;

   logic data_wr_rise, data_rd_fall, rd_rise, wr_rise, ack_fall, mnt_rise;
   logic blk_req, slot_bad, tmo_hit, locked;

   logic [23:0]      tmo_cnt;
   logic [NSLOT-1:0] req_mask;
   logic             req_wr;
   logic             io_done;
   logic [2:0]       fileno;
   logic [1:0]       filetype;
   logic             readonly, mounted;
   logic [31:0]      filesize;

   assign data_wr_rise = data_wr_p2 & ~data_wr_p3;
   assign data_rd_fall = data_rd_p1 & ~zpu_data_rd;
   assign rd_rise      = block_rd & ~block_rd_p1;
   assign wr_rise      = block_wr & ~block_wr_p1;
   assign ack_fall     = ack_p1 & ~sd_ack;
   assign mnt_rise     = (|img_mounted) & ~mnt_p1;
   assign blk_req      = (state == IDLE) & (rd_rise | wr_rise);
   assign slot_bad     = (slot == 2'd3);
   assign tmo_hit      = (state == REQ) & ~sd_ack & (tmo_cnt == TIMEOUT - 24'd1);

   assign zpu_in2 = {readonly, filetype, fileno, mounted, io_done};
   assign zpu_in3 = lba_sel ? filesize : {24'b0, buf_q};

   // FSM state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (blk_req & ~slot_bad) state_nxt = REQ;
         REQ:     if (sd_ack) state_nxt = XFER;
                  else if (tmo_hit) state_nxt = IDLE;
         XFER:    if (ack_fall) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request bit only while waiting for the ack, buffer locked during HPS access
   always_comb begin
      busy   = 1'b0;
      locked = 1'b0;
      sd_rd  = '0;
      sd_wr  = '0;
      case (state)
         REQ: begin
            busy   = 1'b1;
            locked = 1'b1;
            if (req_wr) sd_wr = req_mask;
            else        sd_rd = req_mask;
         end
         XFER: begin
            busy   = 1'b1;
            locked = 1'b1;
         end
         DONE:    busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // request control: strobe history, timeout counter, done/error flags
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         data_wr_p1  <= 1'b0;
         data_wr_p2  <= 1'b0;
         data_wr_p3  <= 1'b0;
         data_rd_p1  <= 1'b0;
         block_rd_p1 <= 1'b0;
         block_wr_p1 <= 1'b0;
         ack_p1      <= 1'b0;
         tmo_cnt     <= '0;
         req_mask    <= '0;
         req_wr      <= 1'b0;
         io_done     <= 1'b0;
         zpu_err     <= 1'b0;
      end else begin
         data_wr_p1  <= zpu_data_wr;
         data_wr_p2  <= data_wr_p1;
         data_wr_p3  <= data_wr_p2;
         data_rd_p1  <= zpu_data_rd;
         block_rd_p1 <= block_rd;
         block_wr_p1 <= block_wr;
         ack_p1      <= sd_ack;
         if (state == REQ) tmo_cnt <= tmo_cnt + 24'd1;
         else              tmo_cnt <= '0;
         if (blk_req) begin
            if (slot_bad) begin
               io_done <= 1'b1;
               zpu_err <= 1'b1;
            end else begin
               io_done  <= 1'b0;
               zpu_err  <= 1'b0;
               req_mask <= NSLOT'(1) << slot;
               req_wr   <= ~rd_rise;   // read wins when both edges coincide
            end
         end else if (tmo_hit) begin
            io_done <= 1'b1;
            zpu_err <= 1'b1;
         end else if (state == DONE) begin
            io_done <= 1'b1;
         end
      end
   end

   // buffer port and LBA register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sd_lba   <= '0;
         buf_wr   <= 1'b0;
         buf_addr <= '0;
      end else begin
         if (data_wr_rise & lba_sel) sd_lba <= zpu_out3;
         buf_wr <= data_wr_rise & ~lba_sel & ~locked;
         if (zpu_io_wr)                   buf_addr <= '0;
         else if (buf_wr | data_rd_fall) buf_addr <= buf_addr + ABITS'(1);
      end
   end

   // mount event latch, active in every FSM state
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mnt_p1   <= 1'b0;
         fileno   <= '0;
         filetype <= '0;
         readonly <= 1'b0;
         mounted  <= 1'b0;
         filesize <= '0;
      end else begin
         mnt_p1 <= |img_mounted;
         if (mnt_rise) begin
            if (img_mounted[2])      fileno <= 3'd4;
            else if (img_mounted[1]) fileno <= 3'd1;
            else                     fileno <= 3'd0;
            filetype <= ioctl_index[7:6];
            readonly <= img_readonly | img_mounted[2];
            filesize <= img_size;
            mounted  <= ~mounted;
         end
      end
   end

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// tb_sd_sector_sequencer: randomized bench for sd_sector_sequencer with a
// behavioural model of buffer pointer, buffer contents, LBA and mount status.
module tb_sd_sector_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] zpu_out2, zpu_out3;
   logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
   logic [7:0]  zpu_in2;
   logic [31:0] zpu_in3;
   logic        zpu_err;
   logic [8:0]  buf_addr;
   logic        buf_wr;
   logic [7:0]  buf_q;
   logic [31:0] sd_lba;
   logic [2:0]  sd_rd, sd_wr;
   logic        sd_ack;
   logic [2:0]  img_mounted;
   logic        img_readonly;
   logic [31:0] img_size;
   logic [7:0]  ioctl_index;
   logic        busy;

   sd_sector_sequencer #(.NSLOT(3), .TIMEOUT(24'd100), .ABITS(9)) dut (
      .clk_sys(clk), .reset_n(reset_n),
      .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
      .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
      .zpu_in2(zpu_in2), .zpu_in3(zpu_in3), .zpu_err(zpu_err),
      .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_q(buf_q),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .img_mounted(img_mounted), .img_readonly(img_readonly),
      .img_size(img_size), .ioctl_index(ioctl_index), .busy(busy)
   );

   always #5 clk = ~clk;

   // sector buffer RAM on port B; data comes from the ZPU data word
   logic [7:0] ram [512];
   int         wr_cnt = 0;
   assign buf_q = ram[buf_addr];
   always @(posedge clk) begin
      if (buf_wr) begin
         ram[buf_addr] <= zpu_out3[7:0];
         wr_cnt        <= wr_cnt + 1;
      end
   end

   // reference model state
   int         exp_addr;
   logic [31:0] exp_lba;
   logic [7:0] exp_mem [512];
   bit         exp_valid [512];
   logic [2:0] exp_fileno;
   logic [1:0] exp_ftype;
   logic       exp_ro, exp_mnt;
   logic [31:0] exp_size;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      exp_addr   = 0;
      exp_lba    = '0;
      exp_fileno = '0;
      exp_ftype  = '0;
      exp_ro     = 1'b0;
      exp_mnt    = 1'b0;
      exp_size   = '0;
   endtask

   task automatic data_write(input logic [31:0] val, input bit lba, input bit locked);
      int c0;
      c0 = wr_cnt;
      zpu_out2[0] = lba;
      zpu_out3    = val;
      zpu_data_wr = 1'b1;
      tick(1);
      zpu_data_wr = 1'b0;
      tick(4);
      if (lba) begin
         exp_lba = val;
         check_val("lba", sd_lba, exp_lba);
         check_val("lba_no_bufwr", wr_cnt - c0, 0);
      end else if (locked) begin
         check_val("locked_bufwr", wr_cnt - c0, 0);
      end else begin
         exp_mem[exp_addr]   = val[7:0];
         exp_valid[exp_addr] = 1'b1;
         exp_addr            = (exp_addr + 1) % 512;
         check_val("bufwr_pulse", wr_cnt - c0, 1);
      end
      check_val("addr_after_wr", buf_addr, exp_addr);
   endtask

   task automatic data_read();
      zpu_out2[0] = 1'b0;
      #1;
      if (exp_valid[exp_addr]) check_val("rdata", zpu_in3, {24'b0, exp_mem[exp_addr]});
      tick(1);
      zpu_data_rd = 1'b1;
      tick(1);
      zpu_data_rd = 1'b0;
      tick(3);
      exp_addr = (exp_addr + 1) % 512;
      check_val("addr_after_rd", buf_addr, exp_addr);
   endtask

   task automatic io_write();
      zpu_io_wr = 1'b1;
      tick(1);
      zpu_io_wr = 1'b0;
      tick(1);
      exp_addr = 0;
      check_val("addr_io_wr", buf_addr, exp_addr);
   endtask

   task automatic mount(input logic [2:0] m, input logic ro, input logic [31:0] size,
                        input logic [7:0] idx);
      img_readonly = ro;
      img_size     = size;
      ioctl_index  = idx;
      img_mounted  = m;
      tick(1);
      img_mounted  = 3'b000;
      tick(2);
      exp_fileno = m[2] ? 3'd4 : (m[1] ? 3'd1 : 3'd0);
      exp_ftype  = idx[7:6];
      exp_ro     = ro | m[2];
      exp_size   = size;
      exp_mnt    = ~exp_mnt;
      zpu_out2[0] = 1'b1;
      #1;
      check_val("mount_status", {25'b0, zpu_in2[7:1]},
                {25'b0, exp_ro, exp_ftype, exp_fileno, exp_mnt});
      check_val("mount_size", zpu_in3, exp_size);
   endtask

   task automatic transfer(input bit is_wr, input logic [2:0] drv, input bit both,
                           input bit extras);
      int         sl, t;
      logic [2:0] m;
      logic       rd_exp;
      sl = {drv[2], drv[0]};
      m  = 3'(1 << sl);
      rd_exp = !is_wr || both;
      zpu_out2[5:3] = drv;
      zpu_out2[1]   = rd_exp;
      zpu_out2[2]   = is_wr || both;
      tick(1);
      zpu_out2[2:1] = 2'b00;
      t = 0;
      while ((sd_rd | sd_wr) == 3'b000 && t < 8) begin
         tick(1);
         t++;
      end
      check_val("req_rd", sd_rd, rd_exp ? m : 3'b000);
      check_val("req_wr", sd_wr, rd_exp ? 3'b000 : m);
      check_val("busy_req", busy, 1);
      check_val("done_low_req", zpu_in2[0], 0);
      check_val("err_cleared", zpu_err, 0);
      if (extras) begin
         data_write(32'($urandom_range(0, 255)), 1'b0, 1'b1);
         data_write($urandom, 1'b1, 1'b1);
         mount(3'($urandom_range(1, 7)), 1'($urandom), $urandom, 8'($urandom));
      end
      tick($urandom_range(1, 10));
      check_val("req_held", sd_rd | sd_wr, m);
      sd_ack = 1'b1;
      t = 0;
      while ((sd_rd | sd_wr) != 3'b000 && t < 8) begin
         tick(1);
         t++;
      end
      check_val("ack_clears_req", sd_rd | sd_wr, 0);
      zpu_out2[1] = 1'b1;
      tick($urandom_range(1, 6));
      check_val("xfer_ignores_blk", sd_rd | sd_wr, 0);
      check_val("done_low_xfer", zpu_in2[0], 0);
      check_val("busy_xfer", busy, 1);
      zpu_out2[1] = 1'b0;
      sd_ack = 1'b0;
      t = 0;
      while (!zpu_in2[0] && t < 10) begin
         tick(1);
         t++;
      end
      check_val("done_latency", t, 2);
      check_val("busy_idle", busy, 0);
   endtask

   task automatic timeout_test(input logic [2:0] drv);
      int cnt, t;
      zpu_out2[5:3] = drv;
      zpu_out2[2]   = 1'b1;
      tick(1);
      zpu_out2[2]   = 1'b0;
      cnt = 0;
      t   = 0;
      while (t < 300) begin
         if (sd_wr == 3'(1 << {drv[2], drv[0]})) cnt++;
         else if (cnt > 0) break;
         tick(1);
         t++;
      end
      check_val("timeout_len", cnt, 100);
      check_val("timeout_wr_clr", sd_wr, 0);
      check_val("timeout_err", zpu_err, 1);
      check_val("timeout_done", zpu_in2[0], 1);
      check_val("timeout_busy", busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] drv;
      zpu_out2 = '0; zpu_out3 = '0;
      zpu_io_wr = 0; zpu_data_wr = 0; zpu_data_rd = 0;
      sd_ack = 0; img_mounted = '0; img_readonly = 0; img_size = '0; ioctl_index = '0;
      for (int i = 0; i < 512; i++) exp_valid[i] = 1'b0;
      model_reset();
      #1 reset_n = 1'b0;
      tick(3);
      check_val("rst_busy", busy, 0);
      check_val("rst_sd_rd", sd_rd, 0);
      check_val("rst_sd_wr", sd_wr, 0);
      check_val("rst_buf_wr", buf_wr, 0);
      check_val("rst_buf_addr", buf_addr, 0);
      check_val("rst_sd_lba", sd_lba, 0);
      check_val("rst_status", zpu_in2, 0);
      check_val("rst_err", zpu_err, 0);
      reset_n = 1'b1;
      tick(2);

      // slot index 3 (drv_num 5) is rejected with done+error
      zpu_out2[5:3] = 3'd5;
      zpu_out2[1]   = 1'b1;
      tick(1);
      zpu_out2[1]   = 1'b0;
      check_val("bad_slot_done", zpu_in2[0], 1);
      check_val("bad_slot_err", zpu_err, 1);
      tick(4);
      check_val("bad_slot_noreq", sd_rd | sd_wr, 0);
      check_val("bad_slot_busy", busy, 0);

      data_write(32'h0000_0123, 1'b1, 1'b0);
      io_write();
      data_write(32'hAA, 1'b0, 1'b0);
      data_write(32'hBB, 1'b0, 1'b0);
      data_write(32'hCC, 1'b0, 1'b0);
      data_write(32'hDD, 1'b0, 1'b0);
      check_val("addr_four", buf_addr, 4);
      io_write();
      for (int i = 0; i < 4; i++) data_read();

      transfer(1'b0, 3'd4, 1'b0, 1'b1);
      timeout_test(3'd1);
      transfer(1'b1, 3'd2, 1'b1, 1'b0);
      mount(3'b010, 1'b0, 32'd92176, 8'h40);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: data_write(32'($urandom_range(0, 255)), 1'b0, 1'b0);
            1: data_write($urandom, 1'b1, 1'b0);
            2: data_read();
            3: io_write();
            4: begin
               do drv = 3'($urandom); while ({drv[2], drv[0]} == 2'b11);
               transfer(1'($urandom), drv, ($urandom_range(0, 3) == 0), 1'($urandom));
            end
            default: mount(3'($urandom_range(1, 7)), 1'($urandom), $urandom, 8'($urandom));
         endcase
      end

      io_write();
      for (int i = 0; i < 513; i++) data_write(32'($urandom_range(0, 255)), 1'b0, 1'b0);
      check_val("addr_wrap", buf_addr, 1);
      for (int i = 0; i < 3; i++) data_read();

      // asynchronous reset while a request is pending
      zpu_out2[5:3] = 3'd4;
      zpu_out2[1]   = 1'b1;
      tick(1);
      zpu_out2[1]   = 1'b0;
      check_val("pre_rst_req", sd_rd, 3'b100);
      reset_n = 1'b0;
      #1;
      check_val("rst_req_sd_rd", sd_rd, 0);
      check_val("rst_req_busy", busy, 0);
      tick(1);
      reset_n = 1'b1;
      model_reset();
      tick(1);

      // asynchronous reset during the data phase
      zpu_out2[1] = 1'b1;
      tick(1);
      zpu_out2[1] = 1'b0;
      sd_ack = 1'b1;
      tick(2);
      check_val("pre_rst_xfer_busy", busy, 1);
      check_val("pre_rst_xfer_rd", sd_rd, 0);
      reset_n = 1'b0;
      #1;
      check_val("rst_xfer_busy", busy, 0);
      check_val("rst_xfer_sd_rd", sd_rd, 0);
      check_val("rst_xfer_status", zpu_in2, 0);
      check_val("rst_xfer_addr", buf_addr, exp_addr);
      check_val("rst_xfer_lba", sd_lba, exp_lba);
      tick(1);
      sd_ack  = 1'b0;
      reset_n = 1'b1;
      tick(2);
      check_val("post_rst_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
